vanilla_decode_queue: RTL and testbench
=======================================

// Module: vanilla_decode_queue
// PURPOSE
//  Parametrised decode-and-buffer stage between fetch and issue in the vanilla core.
//  Accepts raw 32-bit instructions with PC over a ready/valid handshake and decodes each into
//  decode_s / fp_decode_s. Holds results in an els_p-deep circular queue, so fetch runs ahead of
//  issue stalls. Supports pipeline flush and a saturating count of unsupported instructions.
// PARAMETERS
//  els_p        4   queue depth in entries; >=2, power of two
//  pc_width_p   32  PC width carried with each entry
//  cnt_width_p  16  width of the unsupported-instruction counter
// PORTS
//  clk_i              in   1                 clock
//  reset_n_i          in   1                 synchronous active-low reset
//  instr_v_i          in   1                 fetch valid
//  instr_i            in   32                instruction_s
//  pc_i               in   pc_width_p        PC of instr_i
//  instr_ready_o      out  1                 queue can accept this cycle
//  flush_i            in   1                 discard all queued and incoming entries
//  v_o                out  1                 head entry valid
//  instr_o            out  32                head instruction
//  pc_o               out  pc_width_p        head PC
//  decode_o           out  decode_s          head decode
//  fp_decode_o        out  fp_decode_s       head FP decode
//  unsupported_o      out  1                 head is unsupported (mulh/mulhsu/mulhu) or illegal opcode
//  yumi_i             in   1                 issue consumes head; legal only when v_o
//  unsupported_cnt_o  out  cnt_width_p       saturating count of unsupported entries dequeued
// BEHAVIOUR
//  - Reset (reset_n_i==0 at posedge): rd/wr ptrs=0, count=0, unsupported_cnt_o=0; v_o=0.
//    instr_ready_o=0 while reset asserted, 1 the cycle after. Reset mid-transfer drops everything.
//  - Decode is combinational on instr_i at enqueue; the queue stores instr, pc, decode_s,
//    fp_decode_s and unsupported bit. Outputs come from the head entry (no decode on output path).
//  - Enqueue when instr_v_i & instr_ready_o. instr_ready_o = (count != els_p).
//    It does not depend on yumi_i: a full queue with yumi_i does not accept that cycle.
//  - Dequeue when yumi_i & v_o; yumi_i without v_o is an assertion error.
//  - Latency: an entry enqueued at posedge N is at the head (v_o=1) in cycle N+1 if the queue was empty.
//  - Simultaneous enq+deq: count unchanged; both ptrs advance.
//  - Pointers are $clog2(els_p) bits and wrap naturally. count is $clog2(els_p+1) bits.
//  - flush_i priority: it beats enqueue and dequeue in the same cycle.
//    Next cycle: count=0, rd_ptr=wr_ptr; the incoming instr and yumi_i are ignored.
//    v_o is forced 0 during a flush cycle.
//  - Counter: unsupported_cnt_o increments on each dequeue of an entry with unsupported=1.
//    It saturates at all-ones. Flushed entries are not counted.
//  - Illegal opcode: op outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP, OP_IMM, AMO,
//    SYSTEM, MISC_MEM, LOAD_FP, STORE_FP, OP_FP, FMADD/FMSUB/FNMSUB/FNMADD} sets unsupported.
// CONFIGURATION
//  VANILLA_DECODE_QUEUE_BYPASS_EN
//   defined:   when the queue is empty, instr_v_i=1 and flush_i=0, the head outputs come
//              combinationally from the incoming instruction and decode, so v_o=1 in the same
//              cycle (0-cycle latency). If yumi_i is also 1, the entry is not written and ptrs
//              do not move; otherwise it is written normally.
//   undefined: minimum latency is 1 cycle as above; no combinational path from instr_*_i to *_o.
// STRUCTURE
//  - bsg_vanilla_pkg holds decode_s, fp_decode_s, instruction_s and RV32 opcode/funct defines.
//    It also gains the packed vanilla_decode_queue_entry_s {instr, pc, decode, fp_decode, unsupported}.
//    pc is parametrised, so the entry type is declared locally from pc_width_p.
//  - Sub-module vanilla_decode_core: pure combinational instr -> {decode_s, fp_decode_s, unsupported}.
//    It is instantiated once on the enqueue side.
//  - Storage is a flop array of entries (no SRAM); all state updates are on posedge clk_i.
// TESTING
//  1 Fill/drain, els_p=4: enqueue ADD x1,x2,x3 at PCs 0x0,0x4,0x8,0xC with yumi_i=0 ->
//    instr_ready_o=0 after the 4th; drain -> pc_o in order 0x0..0xC, decode_o.write_rd=1, read_rs2=1.
//  2 Full + enq + yumi: queue full, instr_v_i=1, yumi_i=1 -> 1 dequeued, none accepted;
//    next cycle instr_ready_o=1, count=3.
//  3 Flush: 3 entries queued, flush_i=1 with instr_v_i=1 and yumi_i=1 -> next cycle v_o=0,
//    count=0, unsupported_cnt_o unchanged.
//  4 Unsupported: enqueue MULH (0x02001033) then opcode 0x7F -> unsupported_o=1 at head for both;
//    after both dequeue, unsupported_cnt_o=2. With cnt_width_p=2, 5 such dequeues saturate at 3.
//  5 FP decode: FADD.S (0x003100D3) -> fp_decode_o.is_fpu_float_op=1, fpu_float_op=eFADD,
//    decode_o.read_frs1/read_frs2/write_frd=1.
//  6 Bypass (macro defined): empty queue, instr_v_i=1, yumi_i=1 -> v_o=1 same cycle; count stays 0.
//    Macro undefined: v_o=0 that cycle and 1 the next.
//  Also: reset_n_i=0 for 1 cycle mid-stream -> v_o=0, count=0, unsupported_cnt_o=0 next cycle.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// bsg_vanilla_pkg: RV32 instruction layout, opcodes and the decode bundles
// shared by fetch, decode and issue.
package bsg_vanilla_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] op;
  } instruction_s;

  localparam logic [6:0] RV32_LUI_OP      = 7'b0110111;
  localparam logic [6:0] RV32_AUIPC_OP    = 7'b0010111;
  localparam logic [6:0] RV32_JAL_OP      = 7'b1101111;
  localparam logic [6:0] RV32_JALR_OP     = 7'b1100111;
  localparam logic [6:0] RV32_BRANCH_OP   = 7'b1100011;
  localparam logic [6:0] RV32_LOAD_OP     = 7'b0000011;
  localparam logic [6:0] RV32_STORE_OP    = 7'b0100011;
  localparam logic [6:0] RV32_OP          = 7'b0110011;
  localparam logic [6:0] RV32_OP_IMM      = 7'b0010011;
  localparam logic [6:0] RV32_AMO_OP      = 7'b0101111;
  localparam logic [6:0] RV32_SYSTEM_OP   = 7'b1110011;
  localparam logic [6:0] RV32_MISC_MEM_OP = 7'b0001111;
  localparam logic [6:0] RV32_LOAD_FP_OP  = 7'b0000111;
  localparam logic [6:0] RV32_STORE_FP_OP = 7'b0100111;
  localparam logic [6:0] RV32_OP_FP       = 7'b1010011;
  localparam logic [6:0] RV32_FMADD_OP    = 7'b1000011;
  localparam logic [6:0] RV32_FMSUB_OP    = 7'b1000111;
  localparam logic [6:0] RV32_FNMSUB_OP   = 7'b1001011;
  localparam logic [6:0] RV32_FNMADD_OP   = 7'b1001111;
  localparam logic [6:0] RV32_MUL_FUN7    = 7'b0000001;

  typedef enum logic [4:0] {
    eFADD, eFSUB, eFMUL, eFDIV, eFSQRT,
    eFSGNJ, eFSGNJN, eFSGNJX, eFMIN, eFMAX,
    eFCVT_S_W, eFCVT_S_WU, eFMV_W_X,
    eFMADD, eFMSUB, eFNMSUB, eFNMADD
  } fpu_float_op_e;

  typedef enum logic [2:0] {
    eFEQ, eFLT, eFLE, eFCLASS,
    eFCVT_W_S, eFCVT_WU_S, eFMV_X_W
  } fpu_int_op_e;

  typedef struct packed {
    logic write_rd;
    logic read_rs1;
    logic read_rs2;
    logic write_frd;
    logic read_frs1;
    logic read_frs2;
    logic read_frs3;
    logic is_load_op;
    logic is_store_op;
    logic is_branch_op;
    logic is_jal_op;
    logic is_jalr_op;
    logic is_amo_op;
    logic is_csr_op;
    logic is_fp_op;
    logic is_mul_op;
  } decode_s;

  typedef struct packed {
    logic          is_fpu_float_op;
    logic          is_fpu_int_op;
    fpu_float_op_e fpu_float_op;
    fpu_int_op_e   fpu_int_op;
  } fp_decode_s;

  // mulh, mulhsu, mulhu: funct3 1..3 of the M extension
  function automatic logic is_mulh(instruction_s i);
    return (i.op == RV32_OP) && (i.funct7 == RV32_MUL_FUN7)
        && (i.funct3 != 3'b000) && !i.funct3[2];
  endfunction

endpackage

// File: rtl/vanilla_decode_core.sv
// vanilla_decode_core: combinational RV32IMAF decode of one instruction
// into decode_s / fp_decode_s plus an unsupported flag.
module vanilla_decode_core
  import bsg_vanilla_pkg::*;
(
  input  instruction_s instr_i,
  output decode_s      decode_o,
  output fp_decode_s   fp_decode_o,
  output logic         unsupported_o
);

  decode_s    d;
  fp_decode_s f;
  logic       u;
  logic [6:0] op;

  assign op = instr_i.op;

  always_comb begin
    d = '0;
    f = '0;
    u = 1'b0;
    unique case (1'b1)
      (op == RV32_LUI_OP),
      (op == RV32_AUIPC_OP): d.write_rd = 1'b1;
      (op == RV32_JAL_OP): begin
        d.write_rd  = 1'b1;
        d.is_jal_op = 1'b1;
      end
      (op == RV32_JALR_OP): begin
        d.write_rd   = 1'b1;
        d.read_rs1   = 1'b1;
        d.is_jalr_op = 1'b1;
      end
      (op == RV32_BRANCH_OP): begin
        d.read_rs1     = 1'b1;
        d.read_rs2     = 1'b1;
        d.is_branch_op = 1'b1;
      end
      (op == RV32_LOAD_OP): begin
        d.write_rd   = 1'b1;
        d.read_rs1   = 1'b1;
        d.is_load_op = 1'b1;
      end
      (op == RV32_STORE_OP): begin
        d.read_rs1    = 1'b1;
        d.read_rs2    = 1'b1;
        d.is_store_op = 1'b1;
      end
      (op == RV32_OP): begin
        d.write_rd  = 1'b1;
        d.read_rs1  = 1'b1;
        d.read_rs2  = 1'b1;
        d.is_mul_op = (instr_i.funct7 == RV32_MUL_FUN7);
      end
      (op == RV32_OP_IMM): begin
        d.write_rd = 1'b1;
        d.read_rs1 = 1'b1;
      end
      (op == RV32_AMO_OP): begin
        d.write_rd  = 1'b1;
        d.read_rs1  = 1'b1;
        d.read_rs2  = 1'b1;
        d.is_amo_op = 1'b1;
      end
      (op == RV32_SYSTEM_OP): begin
        d.write_rd  = 1'b1;
        d.read_rs1  = 1'b1;
        d.is_csr_op = 1'b1;
      end
      (op == RV32_MISC_MEM_OP): ;
      (op == RV32_LOAD_FP_OP): begin
        d.write_frd  = 1'b1;
        d.read_rs1   = 1'b1;
        d.is_load_op = 1'b1;
      end
      (op == RV32_STORE_FP_OP): begin
        d.read_rs1    = 1'b1;
        d.read_frs2   = 1'b1;
        d.is_store_op = 1'b1;
      end
      (op == RV32_FMADD_OP),
      (op == RV32_FMSUB_OP),
      (op == RV32_FNMSUB_OP),
      (op == RV32_FNMADD_OP): begin
        d.write_frd       = 1'b1;
        d.read_frs1       = 1'b1;
        d.read_frs2       = 1'b1;
        d.read_frs3       = 1'b1;
        d.is_fp_op        = 1'b1;
        f.is_fpu_float_op = 1'b1;
        f.fpu_float_op = op[3]
          ? (op[2] ? eFNMADD : eFNMSUB)
          : (op[2] ? eFMSUB : eFMADD);
      end
      (op == RV32_OP_FP): begin
        d.is_fp_op        = 1'b1;
        d.write_frd       = 1'b1;
        d.read_frs1       = 1'b1;
        f.is_fpu_float_op = 1'b1;
        unique case (instr_i.funct7)
          7'b0000000: begin f.fpu_float_op = eFADD; d.read_frs2 = 1'b1; end
          7'b0000100: begin f.fpu_float_op = eFSUB; d.read_frs2 = 1'b1; end
          7'b0001000: begin f.fpu_float_op = eFMUL; d.read_frs2 = 1'b1; end
          7'b0001100: begin f.fpu_float_op = eFDIV; d.read_frs2 = 1'b1; end
          7'b0101100: f.fpu_float_op = eFSQRT;
          7'b0010000: begin
            d.read_frs2    = 1'b1;
            f.fpu_float_op = instr_i.funct3[1] ? eFSGNJX
                           : (instr_i.funct3[0] ? eFSGNJN : eFSGNJ);
          end
          7'b0010100: begin
            d.read_frs2    = 1'b1;
            f.fpu_float_op = instr_i.funct3[0] ? eFMAX : eFMIN;
          end
          7'b1101000: begin
            d.read_frs1    = 1'b0;
            d.read_rs1     = 1'b1;
            f.fpu_float_op = instr_i.rs2[0] ? eFCVT_S_WU : eFCVT_S_W;
          end
          7'b1111000: begin
            d.read_frs1    = 1'b0;
            d.read_rs1     = 1'b1;
            f.fpu_float_op = eFMV_W_X;
          end
          7'b1010000: begin
            d.read_frs2   = 1'b1;
            f.is_fpu_int_op = 1'b1;
            f.fpu_int_op  = (instr_i.funct3 == 3'b010) ? eFEQ
                          : (instr_i.funct3 == 3'b001) ? eFLT : eFLE;
          end
          7'b1100000: begin
            f.is_fpu_int_op = 1'b1;
            f.fpu_int_op = instr_i.rs2[0] ? eFCVT_WU_S : eFCVT_W_S;
          end
          7'b1110000: begin
            f.is_fpu_int_op = 1'b1;
            f.fpu_int_op = instr_i.funct3[0] ? eFCLASS : eFMV_X_W;
          end
          default: begin
            d.write_frd       = 1'b0;
            d.read_frs1       = 1'b0;
            f.is_fpu_float_op = 1'b0;
          end
        endcase
        // FP ops that produce an integer result retire to rd, not frd
        if (f.is_fpu_int_op) begin
          f.is_fpu_float_op = 1'b0;
          d.write_frd       = 1'b0;
          d.write_rd        = 1'b1;
        end
      end
      default: u = 1'b1;
    endcase
    if (is_mulh(instr_i)) u = 1'b1;
  end

  assign decode_o      = d;
  assign fp_decode_o   = f;
  assign unsupported_o = u;

endmodule

// File: rtl/vanilla_decode_queue.sv
// vanilla_decode_queue: decode at enqueue, buffer in an els_p-deep flop queue.
// Define VANILLA_DECODE_QUEUE_BYPASS_EN for 0-cycle latency into an empty queue.
module vanilla_decode_queue
  import bsg_vanilla_pkg::*;
#(
  parameter int els_p       = 4,
  parameter int pc_width_p  = 32,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   instr_v_i,
  input  logic [31:0]            instr_i,
  input  logic [pc_width_p-1:0]  pc_i,
  output logic                   instr_ready_o,
  input  logic                   flush_i,
  output logic                   v_o,
  output logic [31:0]            instr_o,
  output logic [pc_width_p-1:0]  pc_o,
  output decode_s                decode_o,
  output fp_decode_s             fp_decode_o,
  output logic                   unsupported_o,
  input  logic                   yumi_i,
  output logic [cnt_width_p-1:0] unsupported_cnt_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  typedef struct packed {
    logic [31:0]           instr;
    logic [pc_width_p-1:0] pc;
    decode_s               decode;
    fp_decode_s            fp_decode;
    logic                  unsupported;
  } vanilla_decode_queue_entry_s;

  vanilla_decode_queue_entry_s mem [els_p];
  vanilla_decode_queue_entry_s enq_e, out_e;

  decode_s             dec;
  fp_decode_s          fdec;
  logic                uns;
  logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0] count;
  logic [cnt_width_p-1:0] ucnt;
  logic empty, full, enq, deq, byp, wr, rd;

  vanilla_decode_core u_core (
    .instr_i       (instr_i),
    .decode_o      (dec),
    .fp_decode_o   (fdec),
    .unsupported_o (uns)
  );

  assign enq_e = '{instr: instr_i, pc: pc_i, decode: dec,
                   fp_decode: fdec, unsupported: uns};

  assign empty = (count == '0);
  assign full  = (count == cnt_w_lp'(els_p));

  assign instr_ready_o = reset_n_i & ~full;
  assign enq = instr_v_i & instr_ready_o & ~flush_i;

`ifdef VANILLA_DECODE_QUEUE_BYPASS_EN
  assign byp = empty & instr_v_i & ~flush_i & reset_n_i;
`else
  assign byp = 1'b0;
`endif

  assign out_e = byp ? enq_e : mem[rd_ptr];
  assign v_o   = (~empty & ~flush_i) | byp;
  assign deq   = yumi_i & v_o;

  // a bypassed entry consumed in the same cycle never touches storage
  assign wr = enq & ~(byp & yumi_i);
  assign rd = deq & ~byp;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ucnt   <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ptr_w_lp'(1);
      if (rd) rd_ptr <= rd_ptr + ptr_w_lp'(1);
      count <= count + cnt_w_lp'(wr) - cnt_w_lp'(rd);
      if (deq && out_e.unsupported && !(&ucnt))
        ucnt <= ucnt + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr] <= enq_e;
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && !flush_i)
      assert (!(yumi_i && !v_o));
  end

  assign instr_o           = out_e.instr;
  assign pc_o              = out_e.pc;
  assign decode_o          = out_e.decode;
  assign fp_decode_o       = out_e.fp_decode;
  assign unsupported_o     = out_e.unsupported;
  assign unsupported_cnt_o = ucnt;

endmodule

// File: tb/tb_vanilla_decode_queue.sv
// tb_vanilla_decode_queue: directed table plus hand sequences for
// fill/drain, full+yumi, flush, counter saturation, FP decode, bypass, reset.
module tb_vanilla_decode_queue;
  import bsg_vanilla_pkg::*;

  localparam logic [31:0] ADD    = 32'h003100B3;
  localparam logic [31:0] MULH   = 32'h02001033;
  localparam logic [31:0] MULHSU = 32'h02002033;
  localparam logic [31:0] MULHU  = 32'h02003033;
  localparam logic [31:0] BAD7F  = 32'h0000007F;
  localparam logic [31:0] BAD0B  = 32'h0000000B;
  localparam logic [31:0] FADD   = 32'h003100D3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, instr_v, flush, yumi;
  logic [31:0] instr, pc;

  logic        ready, v, uns;
  logic [31:0] instr_q, pc_q;
  decode_s     dec;
  fp_decode_s  fdec;
  logic [15:0] ucnt;

  logic        s_ready, s_v, s_uns;
  logic [31:0] s_instr, s_pc;
  decode_s     s_dec;
  fp_decode_s  s_fdec;
  logic [1:0]  s_ucnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  vanilla_decode_queue u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .instr_v_i(instr_v),
    .instr_i(instr), .pc_i(pc), .instr_ready_o(ready),
    .flush_i(flush), .v_o(v), .instr_o(instr_q), .pc_o(pc_q),
    .decode_o(dec), .fp_decode_o(fdec), .unsupported_o(uns),
    .yumi_i(yumi), .unsupported_cnt_o(ucnt)
  );

  vanilla_decode_queue #(.cnt_width_p(2)) u_sat (
    .clk_i(clk), .reset_n_i(reset_n), .instr_v_i(instr_v),
    .instr_i(instr), .pc_i(pc), .instr_ready_o(s_ready),
    .flush_i(flush), .v_o(s_v), .instr_o(s_instr), .pc_o(s_pc),
    .decode_o(s_dec), .fp_decode_o(s_fdec), .unsupported_o(s_uns),
    .yumi_i(yumi), .unsupported_cnt_o(s_ucnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  flags; // uns wrd rs1 rs2 wfrd frs1 frs2 fflt
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [31:0] i,
                        input logic [31:0] p, input logic y,
                        input logic f);
    instr_v = iv; instr = i; pc = p; yumi = y; flush = f;
  endtask

  task automatic enq(input logic [31:0] i, input logic [31:0] p);
    set_in(1'b1, i, p, 1'b0, 1'b0);
    tick();
    instr_v = 1'b0;
  endtask

  task automatic deq();
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] flags_now();
    return {uns, dec.write_rd, dec.read_rs1, dec.read_rs2,
            dec.write_frd, dec.read_frs1, dec.read_frs2,
            fdec.is_fpu_float_op};
  endfunction

  initial begin
    vecs[0]  = '{ADD,          8'b0111_0000};
    vecs[1]  = '{MULH,         8'b1111_0000};
    vecs[2]  = '{BAD7F,        8'b1000_0000};
    vecs[3]  = '{FADD,         8'b0000_1111};
    vecs[4]  = '{32'h123452B7, 8'b0100_0000};
    vecs[5]  = '{32'h00012083, 8'b0110_0000};
    vecs[6]  = '{32'h00312023, 8'b0011_0000};
    vecs[7]  = '{32'h023100B3, 8'b0111_0000};
    vecs[8]  = '{MULHU,        8'b1111_0000};
    vecs[9]  = '{32'h00012087, 8'b0010_1000};
    vecs[10] = '{32'h203100C3, 8'b0000_1111};
    vecs[11] = '{32'h000000EF, 8'b0100_0000};
    vecs[12] = '{BAD0B,        8'b1000_0000};
    vecs[13] = '{32'hA03120D3, 8'b0100_0110};

    // reset
    reset_n = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("rst ready", 32'(ready), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst v", 32'(v), 32'd0);
    chk("rst ready after", 32'(ready), 32'd1);
    chk("rst ucnt", 32'(ucnt), 32'd0);

    // decode table, one entry at a time
    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      enq(vecs[i].instr, 32'(i * 4));
      #1;
      chk($sformatf("vec%0d v", i), 32'(v), 32'd1);
      chk($sformatf("vec%0d instr", i), instr_q, vecs[i].instr);
      chk($sformatf("vec%0d flags", i), 32'(flags_now()),
          32'(vecs[i].flags));
      deq();
      exp_cnt += int'(vecs[i].flags[7]);
    end
    #1;
    chk("table ucnt", 32'(ucnt), 32'(exp_cnt));
    chk("table sat ucnt", 32'(s_ucnt), 32'(exp_cnt > 3 ? 3 : exp_cnt));

    // fill and drain
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, ADD, 32'(k * 4), 1'b0, 1'b0);
      #1;
      chk($sformatf("fill ready%0d", k), 32'(ready), 32'd1);
      tick();
    end
    instr_v = 1'b0;
    #1;
    chk("full ready", 32'(ready), 32'd0);
    chk("full count", 32'(u_dut.count), 32'd4);
    yumi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain v%0d", k), 32'(v), 32'd1);
      chk($sformatf("drain pc%0d", k), pc_q, 32'(k * 4));
      chk($sformatf("drain dec%0d", k),
          32'({dec.write_rd, dec.read_rs2}), 32'b11);
      tick();
    end
    yumi = 1'b0;
    #1;
    chk("drained v", 32'(v), 32'd0);

    // full queue with enqueue and yumi in the same cycle
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, ADD, 32'h10 + 32'(k * 4), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, ADD, 32'h100, 1'b1, 1'b0);
    #1;
    chk("fullyumi ready", 32'(ready), 32'd0);
    chk("fullyumi v", 32'(v), 32'd1);
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("fullyumi ready next", 32'(ready), 32'd1);
    chk("fullyumi count", 32'(u_dut.count), 32'd3);
    yumi = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fullyumi pc%0d", k), pc_q, 32'h14 + 32'(k * 4));
      tick();
    end
    yumi = 1'b0;
    #1;
    chk("fullyumi empty", 32'(v), 32'd0);

    // flush beats enqueue and dequeue
    for (int k = 0; k < 3; k++) enq(MULH, 32'h40 + 32'(k * 4));
    set_in(1'b1, ADD, 32'h400, 1'b1, 1'b1);
    #1;
    chk("flush v during", 32'(v), 32'd0);
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("flush v", 32'(v), 32'd0);
    chk("flush count", 32'(u_dut.count), 32'd0);
    chk("flush ucnt", 32'(ucnt), 32'(exp_cnt));
    enq(ADD, 32'h200);
    #1;
    chk("postflush v", 32'(v), 32'd1);
    chk("postflush pc", pc_q, 32'h200);
    deq();

    // unsupported counting and saturation
    do_reset();
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: enq(MULH, 32'h0);
        1: enq(BAD7F, 32'h4);
        2: enq(MULHSU, 32'h8);
        3: enq(MULHU, 32'hC);
        default: enq(BAD0B, 32'h10);
      endcase
      #1;
      chk($sformatf("uns head%0d", k), 32'(uns), 32'd1);
      deq();
      exp_cnt++;
      #1;
      chk($sformatf("uns cnt%0d", k), 32'(ucnt), 32'(exp_cnt));
      chk($sformatf("uns sat%0d", k), 32'(s_ucnt),
          32'(exp_cnt > 3 ? 3 : exp_cnt));
    end

    // FP decode
    enq(FADD, 32'h80);
    #1;
    chk("fadd float", 32'(fdec.is_fpu_float_op), 32'd1);
    chk("fadd op", 32'(fdec.fpu_float_op), 32'(eFADD));
    chk("fadd regs", 32'({dec.read_frs1, dec.read_frs2, dec.write_frd}),
        32'b111);
    deq();
    enq(32'hA03120D3, 32'h84);
    #1;
    chk("feq int", 32'(fdec.is_fpu_int_op), 32'd1);
    chk("feq op", 32'(fdec.fpu_int_op), 32'(eFEQ));
    deq();

    // empty-queue latency
`ifdef VANILLA_DECODE_QUEUE_BYPASS_EN
    set_in(1'b1, ADD, 32'h300, 1'b1, 1'b0);
    #1;
    chk("bypass v", 32'(v), 32'd1);
    chk("bypass pc", pc_q, 32'h300);
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("bypass count", 32'(u_dut.count), 32'd0);
    chk("bypass v next", 32'(v), 32'd0);
`else
    set_in(1'b1, ADD, 32'h300, 1'b0, 1'b0);
    #1;
    chk("latency v same", 32'(v), 32'd0);
    tick();
    instr_v = 1'b0;
    #1;
    chk("latency v next", 32'(v), 32'd1);
    chk("latency pc", pc_q, 32'h300);
    deq();
`endif

    // reset mid-stream
    enq(MULH, 32'h500);
    enq(MULH, 32'h504);
    deq();
    exp_cnt++;
    #1;
    chk("pre-reset ucnt", 32'(ucnt), 32'(exp_cnt));
    set_in(1'b1, ADD, 32'h600, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst ready", 32'(ready), 32'd0);
    tick();
    reset_n = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("midrst v", 32'(v), 32'd0);
    chk("midrst count", 32'(u_dut.count), 32'd0);
    chk("midrst ucnt", 32'(ucnt), 32'd0);
    chk("midrst sat ucnt", 32'(s_ucnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
